// File: rtl/counter.sv
// Free-running modulo-2^WIDTH up-counter with synchronous, active-high reset.
// The count register is the only state and drives out_o directly.
module counter #(
  parameter int unsigned     WIDTH       = 8,
  parameter longint unsigned STEP        = 1,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic [WIDTH-1:0] out_o
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  // Parameter legality: abort elaboration on an unusable configuration.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "counter: WIDTH must be in 1..64");
  end
  if (STEP == 0) begin : g_zero_step
    $fatal(1, "counter: STEP must be nonzero");
  end
  if (WIDTH < 64) begin : g_range
    if ((STEP >> WIDTH) != 0) begin : g_bad_step
      $fatal(1, "counter: STEP must be below 2**WIDTH");
    end
    if ((RESET_VALUE >> WIDTH) != 0) begin : g_bad_reset
      $fatal(1, "counter: RESET_VALUE must fit in WIDTH bits");
    end
  end

  // Count register: reset wins over increment; carry out of the MSB is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_o <= RESET_W;
    end else begin
      out_o <= out_o + STEP_W;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Directed, table-driven bench for counter across three parameter sets.
module tb_counter;

  logic       clk;
  logic       rst0, rst1, rst2;
  logic [7:0] out0;
  logic [3:0] out1;
  logic [7:0] out2;

  int checks   = 0;
  int failures = 0;

  counter u_dut0 (.clk_i(clk), .reset_i(rst0), .out_o(out0));

  counter #(.WIDTH(4), .STEP(3), .RESET_VALUE(5)) u_dut1 (
    .clk_i(clk), .reset_i(rst1), .out_o(out1)
  );

  counter #(.WIDTH(8), .STEP(1), .RESET_VALUE(7)) u_dut2 (
    .clk_i(clk), .reset_i(rst2), .out_o(out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    int unsigned reps;
    logic [7:0]  exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[15];
  int unsigned seq1[6];

  initial begin
    vecs[0]  = '{1'b1, 1,   8'd0};
    vecs[1]  = '{1'b1, 1,   8'd0};
    vecs[2]  = '{1'b0, 1,   8'd1};
    vecs[3]  = '{1'b0, 1,   8'd2};
    vecs[4]  = '{1'b0, 1,   8'd3};
    vecs[5]  = '{1'b0, 34,  8'd37};
    vecs[6]  = '{1'b1, 1,   8'd0};
    vecs[7]  = '{1'b0, 1,   8'd1};
    vecs[8]  = '{1'b0, 1,   8'd2};
    vecs[9]  = '{1'b0, 1,   8'd3};
    vecs[10] = '{1'b1, 1,   8'd0};
    vecs[11] = '{1'b0, 255, 8'd255};
    vecs[12] = '{1'b0, 1,   8'd0};
    vecs[13] = '{1'b0, 1,   8'd1};
    vecs[14] = '{1'b0, 1,   8'd2};
    seq1 = '{5, 8, 11, 14, 1, 4};

    // Reset for the edges at 5 and 15 ns, then free-run to 520 ns.
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    #10;
    check("reset_state", 64'(out0), 64'd0);
    #10;
    rst0 = 1'b0;
    #500;
    check("free_run_50", 64'(out0), 64'd50);

    // Default instance: reset hold, mid-count reset, wrap-around.
    for (int i = 0; i < 15; i++) begin
      rst0 = vecs[i].rst;
      for (int unsigned k = 0; k < vecs[i].reps; k++) tick();
      check($sformatf("vec%0d", i), 64'(out0), 64'(vecs[i].exp));
    end
    rst0 = 1'b1;

    // WIDTH=4, STEP=3, RESET_VALUE=5: held in reset so far.
    check("w4_held", 64'(out1), 64'd5);
    tick();
    rst1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("w4_seq%0d", i), 64'(out1), 64'(seq1[i]));
      tick();
    end
    rst1 = 1'b1;

    // RESET_VALUE=7: reset must win on the wrap edge.
    check("rv7_held", 64'(out2), 64'd7);
    rst2 = 1'b0;
    for (int i = 0; i < 248; i++) tick();
    check("rv7_at_255", 64'(out2), 64'd255);
    rst2 = 1'b1;
    tick();
    check("rv7_reset_on_wrap", 64'(out2), 64'd7);
    rst2 = 1'b0;
    tick();
    check("rv7_resume", 64'(out2), 64'd8);
    tick();
    check("rv7_resume2", 64'(out2), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
